// File: rtl/display_pkg.sv
// Shared constants for the four-digit multiplexed display.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Code driven to the segment decoder when a position must appear dark.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Anode pattern per scan index (active-low, one-hot-low); entry 0 is rightmost.
  localparam logic [NUM_DIGITS-1:0][3:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Look up the anode pattern for a scan index.
  function automatic logic [3:0] index_to_an(input logic [1:0] idx);
    return AN_TABLE[idx];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter producing a registered one-cycle pulse while the count
// sits at N-1, i.e. in the cycle whose closing edge wraps the count to 0.
module tick_gen #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;

  // Next count wraps at N-1; the pulse is precomputed so it is a flop output.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (count_q == LAST) begin
      count_d = {W{1'b0}};
    end else begin
      count_d = count_q + ONE;
    end
    wrap_d = (count_d == LAST);
  end

  // Counter and pulse registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: rtl/display_mux.sv
// Four-digit time-multiplexed display driver with per-position blinking.
// Optional leading-zero blanking of the leftmost digit is enabled by
// defining DISPLAY_MUX_LEAD_ZERO_BLANK_EN.
module display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blink_mask,
  output logic [3:0] digit_out,
  output logic [3:0] an,
  output logic       scan_tick
);

  logic       refresh_wrap_s;
  logic       blink_wrap_s;
  logic [1:0] index_q, index_d;
  logic       blink_on_q, blink_on_d;
  logic [3:0] an_q, an_d;
  logic [3:0] digit_out_q, digit_out_d;
  logic [3:0] sel_digit_s;
  logic       blank_s;

  tick_gen #(.N(REFRESH_DIV)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .wrap (refresh_wrap_s)
  );

  tick_gen #(.N(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .wrap (blink_wrap_s)
  );

  // Scan index advance and blink phase toggle.
  always_comb begin
    index_d    = index_q;
    blink_on_d = blink_on_q;
    if (refresh_wrap_s) begin
      index_d = index_q + 2'd1;
    end else begin
      index_d = index_q;
    end
    if (blink_wrap_s) begin
      blink_on_d = ~blink_on_q;
    end else begin
      blink_on_d = blink_on_q;
    end
  end

  // Select the active digit and decide whether it is blanked.
  always_comb begin
    sel_digit_s = digit0;
    blank_s     = 1'b0;
    case (index_q)
      2'd0:    sel_digit_s = digit0;
      2'd1:    sel_digit_s = digit1;
      2'd2:    sel_digit_s = digit2;
      2'd3:    sel_digit_s = digit3;
      default: sel_digit_s = BLANK_CODE;
    endcase
    blank_s = ~blink_on_q & blink_mask[index_q];
`ifdef DISPLAY_MUX_LEAD_ZERO_BLANK_EN
    // A zero in the minutes-tens position is suppressed; blink and this
    // coinciding still produce the single blank code.
    if ((index_q == 2'd3) && (digit3 == 4'd0)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = ~blink_on_q & blink_mask[index_q];
    end
`else
    blank_s = ~blink_on_q & blink_mask[index_q];
`endif
    if (blank_s) begin
      digit_out_d = BLANK_CODE;
    end else begin
      digit_out_d = sel_digit_s;
    end
    an_d = index_to_an(index_q);
  end

  // State and output registers; reset forces all anodes off and a blank code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q     <= 2'd0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      digit_out_q <= BLANK_CODE;
    end else begin
      index_q     <= index_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      digit_out_q <= digit_out_d;
    end
  end

  assign an        = an_q;
  assign digit_out = digit_out_q;
  assign scan_tick = refresh_wrap_s;

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with REFRESH_DIV=4, BLINK_DIV=16.
module tb_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit0, digit1, digit2, digit3, blink_mask;
  logic [3:0] digit_out, an;
  logic       scan_tick;

  int checks = 0;
  int errors = 0;

  display_mux #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .blink_mask (blink_mask),
    .digit_out  (digit_out),
    .an         (an),
    .scan_tick  (scan_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] an_of(input int s);
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [3:0] d_e,
                     input logic t_e, input bit onehot);
    checks++;
    assert (an === an_e) else begin
      errors++;
      $error("FAIL %s an: observed %b expected %b", tag, an, an_e);
    end
    checks++;
    assert (digit_out === d_e) else begin
      errors++;
      $error("FAIL %s digit_out: observed %h expected %h", tag, digit_out, d_e);
    end
    checks++;
    assert (scan_tick === t_e) else begin
      errors++;
      $error("FAIL %s scan_tick: observed %b expected %b", tag, scan_tick, t_e);
    end
    if (onehot) begin
      checks++;
      assert ($countones(~an) == 1) else begin
        errors++;
        $error("FAIL %s onehot: observed %0d low bits expected 1", tag, $countones(~an));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges, check the async clear, release on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk(tag, 4'b1111, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s;
    bit on;
    bit lz;
    logic [3:0] d_e;
`ifdef DISPLAY_MUX_LEAD_ZERO_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
    blink_mask = 4'b0000;

    // Power-on reset state.
    @(negedge clk);
    @(negedge clk);
    chk("por", 4'b1111, 4'hF, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic scan; digit0 changes before edge 3 and is seen immediately.
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) digit0 = 4'd7;
      step();
      s = ((k - 1) / 4) % 4;
      d_e = (s == 0) ? ((k >= 3) ? 4'd7 : 4'd1) : 4'(s + 1);
      chk($sformatf("scan%0d", k), an_of(s), d_e, (k % 4) == 3, 1'b1);
    end
    digit0 = 4'd1;

    // Reset mid-slot at index 2, then a full fresh slot 0.
    do_reset("rst_a");
    for (int k = 1; k <= 10; k++) step();
    chk("pre_mid", an_of(2), 4'd3, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 chk("mid_rst", 4'b1111, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      s = ((k - 1) / 4) % 4;
      chk($sformatf("restart%0d", k), an_of(s), 4'(s + 1), (k % 4) == 3, 1'b1);
    end

    // Blink on position 0 only.
    do_reset("rst_b");
    blink_mask = 4'b0001;
    for (int k = 1; k <= 64; k++) begin
      step();
      s = ((k - 1) / 4) % 4;
      on = (((k - 1) / 16) % 2) == 0;
      d_e = (s == 0) ? (on ? 4'd1 : 4'hF) : 4'(s + 1);
      chk($sformatf("blink%0d", k), an_of(s), d_e, (k % 4) == 3, 1'b1);
    end

    // Pass-through of code C, zero in position 3, blink on position 3.
    do_reset("rst_d");
    digit1 = 4'hC; digit3 = 4'd0; blink_mask = 4'b1000;
    for (int k = 1; k <= 32; k++) begin
      step();
      s = ((k - 1) / 4) % 4;
      on = (((k - 1) / 16) % 2) == 0;
      case (s)
        0:       d_e = 4'd1;
        1:       d_e = 4'hC;
        2:       d_e = 4'd3;
        default: d_e = (!on || lz) ? 4'hF : 4'd0;
      endcase
      chk($sformatf("lz%0d", k), an_of(s), d_e, (k % 4) == 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit scan slot (1 kHz slot rate at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 50000000, clk cycles per blink half-period.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port digit0  input  4  BCD for position 0, rightmost (seconds ones).
REQ-006 SHALL have port digit1  input  4  BCD for position 1 (seconds tens).
REQ-007 SHALL have port digit2  input  4  BCD for position 2 (minutes ones).
REQ-008 SHALL have port digit3  input  4  BCD for position 3, leftmost (minutes tens).
REQ-009 SHALL have port blink_mask  input  4  bit i=1 makes position i blink.
REQ-010 SHALL have port digit_out  output  4  code for the active position, consumed by the downstream BCD-to-segment decoder.
REQ-011 SHALL have port an  output  4  anode enables, active-low, one-hot-low.
REQ-012 SHALL have port scan_tick  output  1  one-cycle pulse at each slot advance.

Function
REQ-013 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0; scan_tick SHALL be high exactly in the wrap cycle.
REQ-014 SHALL hold a 2-bit scan index; on scan_tick it SHALL advance 0->1->2->3->0.
REQ-015 SHALL register an and digit_out; both SHALL reflect the current index and inputs with 1-cycle latency.
REQ-016 an SHALL be 1110, 1101, 1011, 0111 for index 0, 1, 2, 3; only one bit SHALL be low at any time after the first post-reset edge.
REQ-017 digit_out SHALL equal digitN for index N unless it is blanked.
REQ-018 Blanking SHALL output 4'hF with the anode still asserted; the downstream decoder renders all segments off.
REQ-019 SHALL run a blink counter 0..BLINK_DIV-1; on wrap it SHALL toggle blink_on.
REQ-020 When blink_on=0 and blink_mask[index]=1, digit_out SHALL be blanked.
REQ-021 Input codes 10..15 SHALL pass through unmodified.
REQ-022 Input and blink_mask changes SHALL take effect on the next clock, with no resynchronisation of the scan.
REQ-023 Blink and leading-zero blanking coinciding (REQ-029) SHALL yield a single blank, 4'hF.

Reset
REQ-024 On rst=1, asynchronously: refresh counter=0, blink counter=0, index=0, blink_on=1, an=4'b1111, digit_out=4'hF, scan_tick=0.
REQ-025 After rst deasserts, the first rising edge SHALL drive an=1110 and digit_out=digit0.
REQ-026 Reset asserted mid-slot or mid-blink SHALL abandon the slot or blink phase; there is no partial-state carryover.

Configuration
REQ-027 The feature SHALL be controlled by macro DISPLAY_MUX_LEAD_ZERO_BLANK_EN.
REQ-028 Without the macro, digit3=0 SHALL display as 0.
REQ-029 With the macro, index 3 and digit3=4'd0 SHALL output 4'hF; no other position SHALL be affected.

Structure
REQ-030 Shared package display_pkg SHALL hold NUM_DIGITS=4, BLANK_CODE=4'hF, and the index-to-anode constant table.
REQ-031 Sub-module tick_gen SHALL be a parameterised modulo-N counter with a wrap pulse, instantiated twice: refresh and blink.
REQ-032 tick_gen SHALL reset asynchronously on rst, active-high.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-033 Reset release with digits 1,2,3,4 -> an 1110/digit_out 1 for 4 cycles, then 1101/2, 1011/3, 0111/4, then wrap to 1110/1; scan_tick every 4th cycle.
REQ-034 blink_mask=0001 -> position 0 shows digit0 for 16 cycles, then 4'hF for 16 cycles, repeating; other positions unaffected.
REQ-035 rst pulsed mid-slot at index 2 -> an=1111 and digit_out=F immediately; after release, restarts at index 0 with a full 4-cycle slot.
REQ-036 digit3=0 -> with the macro: position 3 shows F; without the macro: shows 0; digit3=0 with blink_mask=1000 in the off phase -> F.
REQ-037 digit1=4'hC -> digit_out=C in slot 1; throughout the run, exactly one an bit SHALL be low on every cycle.
